// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: default widths, the entry
// record, and the word-granular address compare.
package store_buffer_pkg;

  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int SB_DEPTH = 4;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  // Two byte addresses name the same word when they differ only in bits [1:0].
  function automatic logic word_match(input logic [SB_AW-1:0] a,
                                      input logic [SB_AW-1:0] b);
    return ((a ^ b) >> 2) == '0;
  endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// Youngest-match search over the pending store entries for a load lookup.
// The match index output exists only when STORE_BUFFER_FWD_EN is defined.
module sb_fwd_select
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [SB_AW-1:0] entry_addr [DEPTH],
  input  logic [DEPTH-1:0] valid,
  input  logic [PW-1:0]    head,
  input  logic [SB_AW-1:0] ld_addr,
`ifdef STORE_BUFFER_FWD_EN
  output logic [PW-1:0]    idx,
`endif
  output logic             hit
);

  // Walk from oldest (head) to youngest so a later match overrides an older one.
  always_comb begin
    logic [PW-1:0] slot;
    hit  = 1'b0;
    slot = head;
`ifdef STORE_BUFFER_FWD_EN
    idx  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      slot = head + PW'(k);
      if (valid[slot] && word_match(entry_addr[slot], ld_addr)) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        idx = slot;
`endif
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the store path and dataMemory, with load lookup.
// Define STORE_BUFFER_FWD_EN to forward matching store data on ld_data.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          st_valid,
  input  logic [AW-1:0] st_addr,
  input  logic [DW-1:0] st_data,
  output logic          st_ready,
  input  logic [AW-1:0] ld_addr,
  output logic          ld_hit,
  output logic [DW-1:0] ld_data,
  input  logic          mem_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_writeData,
  output logic          mem_writeEnable,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshakes: a store transfers on a rising edge where st_valid && st_ready;
  // a write drains on a rising edge where mem_writeEnable && mem_ready. ready
  // never depends on valid in the same cycle, and st_ready uses only the
  // registered count, so a full buffer gets no credit from a concurrent pop.

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  sb_entry_t     entries [DEPTH];
  logic [SB_AW-1:0] entry_addr [DEPTH];
  logic [DEPTH-1:0] valid;
  logic push, pop;

  assign st_ready        = (count != CW'(DEPTH));
  assign empty           = (count == '0);
  assign mem_writeEnable = !empty;
  assign push            = st_valid && st_ready;
  assign pop             = mem_writeEnable && mem_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset; only slots inside [head, head+count) are ever read.
  always_ff @(posedge clk) begin
    if (push) entries[tail] <= '{addr: st_addr, data: st_data};
  end

  assign mem_addr      = empty ? '0 : entries[head].addr;
  assign mem_writeData = empty ? '0 : entries[head].data;

  // A slot is pending when its distance from head is below count.
  always_comb begin
    logic [PW-1:0] age;
    age   = '0;
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      age      = PW'(i) - head;
      valid[i] = ({1'b0, age} < count);
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) entry_addr[i] = entries[i].addr;
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PW-1:0] fwd_idx;

  sb_fwd_select #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .entry_addr (entry_addr),
    .valid      (valid),
    .head       (head),
    .ld_addr    (ld_addr),
    .idx        (fwd_idx),
    .hit        (ld_hit)
  );

  assign ld_data = ld_hit ? entries[fwd_idx].data : '0;
`else
  sb_fwd_select #(.DEPTH(DEPTH), .PW(PW)) u_fwd (
    .entry_addr (entry_addr),
    .valid      (valid),
    .head       (head),
    .ld_addr    (ld_addr),
    .hit        (ld_hit)
  );

  // Without forwarding, a hit is a stall request and the data path is absent.
  assign ld_data = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: queue-based reference model with a
// per-cycle compare, an in-order write scoreboard, and literal spot checks.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int W     = AW + DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          st_valid = 1'b0;
  logic [AW-1:0] st_addr = '0;
  logic [DW-1:0] st_data = '0;
  logic          st_ready;
  logic [AW-1:0] ld_addr = '0;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_ready = 1'b1;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_writeData;
  logic          mem_writeEnable;
  logic          empty;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] mdl_q[$];   // pending stores as the model sees them after each edge
  logic [W-1:0] exp_q[$];   // stores still owed to dataMemory, in order

  store_buffer dut (
    .clk             (clk),
    .reset           (reset),
    .st_valid        (st_valid),
    .st_addr         (st_addr),
    .st_data         (st_data),
    .st_ready        (st_ready),
    .ld_addr         (ld_addr),
    .ld_hit          (ld_hit),
    .ld_data         (ld_data),
    .mem_ready       (mem_ready),
    .mem_addr        (mem_addr),
    .mem_writeData   (mem_writeData),
    .mem_writeEnable (mem_writeEnable),
    .empty           (empty)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    st_valid = 1'b1;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic drain();
    int cyc;
    cyc = 0;
    while (!empty && cyc < 50) begin
      tick();
      cyc++;
    end
    chk("drain_empty", 64'(empty), 64'd1);
  endtask

  // Youngest pending store to the same word as a, or no hit.
  function automatic logic [DW:0] model_lookup(input logic [AW-1:0] a);
    for (int i = mdl_q.size() - 1; i >= 0; i--) begin
      if (mdl_q[i][W-1:DW+2] == a[AW-1:2]) return {1'b1, mdl_q[i][DW-1:0]};
    end
    return '0;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mdl_q.delete();
      exp_q.delete();
    end else begin
      logic do_push, do_pop;
      do_push = st_valid && (mdl_q.size() < DEPTH);
      do_pop  = (mdl_q.size() > 0) && mem_ready;
      if (do_pop) void'(mdl_q.pop_front());
      if (do_push) begin
        mdl_q.push_back({st_addr, st_data});
        exp_q.push_back({st_addr, st_data});
      end
    end
  end

  // ---------------- per-cycle compare + write scoreboard ----------------
  always @(negedge clk) begin
    logic [DW:0]  lk;
    logic [W-1:0] head_e;
    int n;
    n      = mdl_q.size();
    head_e = (n > 0) ? mdl_q[0] : '0;
    lk     = model_lookup(ld_addr);
    chk("st_ready", 64'(st_ready), 64'(n != DEPTH));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("mem_writeEnable", 64'(mem_writeEnable), 64'(n != 0));
    chk("mem_addr", 64'(mem_addr), 64'(head_e[W-1:DW]));
    chk("mem_writeData", 64'(mem_writeData), 64'(head_e[DW-1:0]));
    chk("ld_hit", 64'(ld_hit), 64'(lk[DW]));
`ifdef STORE_BUFFER_FWD_EN
    chk("ld_data", 64'(ld_data), 64'(lk[DW-1:0]));
`else
    chk("ld_data", 64'(ld_data), 64'd0);
`endif
    if (!reset && mem_writeEnable && mem_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_write", 64'({mem_addr, mem_writeData}), 64'd0);
      end else begin
        chk("write_order", 64'({mem_addr, mem_writeData}), 64'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic accepted;
    int guard;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_st_ready", 64'(st_ready), 64'd1);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_we", 64'(mem_writeEnable), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_ld_hit", 64'(ld_hit), 64'd0);

    // Single store, visible one cycle after the push, gone the cycle after.
    mem_ready = 1'b1;
    drive_store(32'h8, 32'd42);
    tick();
    st_valid = 1'b0;
    chk("t1_we", 64'(mem_writeEnable), 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'h8);
    chk("t1_data", 64'(mem_writeData), 64'd42);
    tick();
    chk("t1_empty", 64'(empty), 64'd1);

    // Fill while stalled, hold a fifth store, then release.
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'(4 * i), 32'(100 + i));
      tick();
    end
    chk("t2_full", 64'(st_ready), 64'd0);
    drive_store(32'h20, 32'h55);
    tick();
    chk("t2_held", 64'(st_ready), 64'd0);
    chk("t2_head", 64'(mem_addr), 64'h0);
    mem_ready = 1'b1;
    tick();
    chk("t2_ready_after_pop", 64'(st_ready), 64'd1);
    chk("t2_head2", 64'(mem_addr), 64'h4);
    tick();
    st_valid = 1'b0;
    chk("t2_head3", 64'(mem_addr), 64'h8);
    chk("t2_data3", 64'(mem_writeData), 64'd102);
    drain();

    // Ten stores with drain throttled to every other cycle.
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_store(32'h100 + 32'(4 * i), 32'h1000 + 32'(7 * i));
      accepted = 1'b0;
      guard    = 0;
      while (!accepted && guard < 20) begin
        mem_ready = ~mem_ready;
        accepted  = st_ready;
        tick();
        guard++;
      end
      chk("t3_accept", 64'(accepted), 64'd1);
    end
    st_valid  = 1'b0;
    mem_ready = 1'b1;
    drain();

    // Two stores to one word; the younger one must win the lookup.
    mem_ready = 1'b0;
    drive_store(32'h10, 32'd5);
    tick();
    drive_store(32'h10, 32'd7);
    tick();
    st_valid = 1'b0;
    ld_addr  = 32'h12;
    #1;
    chk("t4_hit", 64'(ld_hit), 64'd1);
`ifdef STORE_BUFFER_FWD_EN
    chk("t4_data", 64'(ld_data), 64'd7);
`else
    chk("t4_data", 64'(ld_data), 64'd0);
`endif
    ld_addr = 32'h14;
    #1;
    chk("t4_miss", 64'(ld_hit), 64'd0);

    // Push and pop together at count 2, then at count 4.
    mem_ready = 1'b1;
    drive_store(32'h30, 32'd9);
    tick();
    st_valid  = 1'b0;
    mem_ready = 1'b0;
    chk("t5_head_addr", 64'(mem_addr), 64'h10);
    chk("t5_head_data", 64'(mem_writeData), 64'd7);
    drive_store(32'h34, 32'hA);
    tick();
    drive_store(32'h38, 32'hB);
    tick();
    st_valid = 1'b0;
    chk("t5_full", 64'(st_ready), 64'd0);
    mem_ready = 1'b1;
    drive_store(32'h3C, 32'hC);
    #1;
    chk("t5_no_credit", 64'(st_ready), 64'd0);
    tick();
    chk("t5_ready_again", 64'(st_ready), 64'd1);
    chk("t5_head_after", 64'(mem_writeData), 64'd9);
    tick();
    st_valid = 1'b0;
    drain();

    // Asynchronous reset with three stores pending.
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_store(32'h40 + 32'(4 * i), 32'(200 + i));
      tick();
    end
    st_valid = 1'b0;
    ld_addr  = 32'h44;
    #1;
    chk("t6_pre_hit", 64'(ld_hit), 64'd1);
    reset = 1'b1;
    #1;
    chk("t6_we", 64'(mem_writeEnable), 64'd0);
    chk("t6_empty", 64'(empty), 64'd1);
    chk("t6_ready", 64'(st_ready), 64'd1);
    chk("t6_addr", 64'(mem_addr), 64'd0);
    chk("t6_hit", 64'(ld_hit), 64'd0);
    mem_ready = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("t6_still_empty", 64'(empty), 64'd1);

    tick();
    chk("leftover_writes", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
